// File: rtl/async_receiver_word.sv
// async_receiver_word: 8N1 serial receiver with 16x oversampling, framing
// error detection and pairing of consecutive bytes into a 16-bit word
// (first byte in the high half). rx_idle marks a long mark-level gap, which
// also drops any half-assembled word.
`timescale 1ns/1ps

module async_receiver_word #(
  parameter int unsigned ClkFrequency = 50000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 16,
  parameter int unsigned AccWidth     = 16,
  parameter int unsigned IdleBits     = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RxD,
  output logic [7:0]  rx_data,
  output logic        rx_data_ready,
  output logic        rx_frame_err,
  output logic [15:0] rx_word,
  output logic        rx_word_valid,
  output logic        rx_idle
);

  // Phase-accumulator increment; rounded so the tick rate tracks Baud*16.
  localparam logic [63:0] AccIncL =
      (((64'(Baud) * 64'(Oversampling)) << (AccWidth - 7)) + (64'(ClkFrequency) >> 8))
      / (64'(ClkFrequency) >> 7);
  localparam logic [AccWidth:0] AccInc  = (AccWidth + 1)'(AccIncL);
  localparam logic [11:0]       IdleMax = 12'(IdleBits * 16);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  logic [AccWidth:0] acc_q, acc_d;
  logic [1:0]        sync_q;
  logic [2:0]        filt_sh_q, filt_sh_d;
  logic [2:0]        state_q, state_d;
  logic [3:0]        phase_q, phase_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [11:0]       idle_cnt_q, idle_cnt_d;
  logic              idle_q, idle_d;
  logic              pending_q, pending_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        data_q, data_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [15:0]       word_q, word_d;
  logic              word_valid_q, word_valid_d;

  logic tick_s;
  logic filt_s;
  logic filt_nxt_s;
  logic byte_done_s;
  logic frame_err_s;
  logic idle_rise_s;

  assign tick_s     = acc_q[AccWidth];
  assign filt_s     = maj3(filt_sh_q);
  assign filt_nxt_s = maj3(filt_sh_d);
  assign acc_d      = {1'b0, acc_q[AccWidth-1:0]} + AccInc;

  // Oversample filter shifts in the synchronised line only on a tick.
  always_comb begin
    filt_sh_d = filt_sh_q;
    if (tick_s) begin
      filt_sh_d = {filt_sh_q[1:0], sync_q[1]};
    end else begin
      filt_sh_d = filt_sh_q;
    end
  end

  // Frame FSM: start-bit qualification at mid-bit, 8 data bits LSB first, stop check.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    byte_done_s = 1'b0;
    frame_err_s = 1'b0;
    if (tick_s) begin
      case (state_q)
        StIdle: begin
          if (!filt_s) begin
            state_d = StStart;
            phase_d = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end
        StStart: begin
          if (phase_q == 4'd7) begin
            phase_d = 4'd0;
            if (!filt_s) begin
              state_d  = StData;
              bitcnt_d = 3'd0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
        StData: begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd15) begin
            shift_d = {filt_s, shift_q[7:1]};
            if (bitcnt_q == 3'd7) begin
              state_d = StStop;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        StStop: begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd15) begin
            if (filt_s) begin
              byte_done_s = 1'b1;
              state_d     = StIdle;
            end else begin
              frame_err_s = 1'b1;
              state_d     = StBreak;
            end
          end else begin
            state_d = StStop;
          end
        end
        StBreak: begin
          if (filt_s) begin
            state_d = StIdle;
          end else begin
            state_d = StBreak;
          end
        end
        default: begin
          state_d = StIdle;
          phase_d = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Idle detector: saturating count of mark ticks while waiting for a start bit.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!filt_nxt_s) begin
      idle_cnt_d = 12'd0;
    end else if (tick_s && (state_q == StIdle) && (idle_cnt_q != IdleMax)) begin
      idle_cnt_d = idle_cnt_q + 12'd1;
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
    idle_d      = (idle_cnt_d == IdleMax);
    idle_rise_s = idle_d & ~idle_q;
  end

  // Byte output and word pairing; errors or a fresh idle gap drop a half word.
  always_comb begin
    data_d       = data_q;
    ready_d      = byte_done_s;
    err_d        = frame_err_s;
    hi_d         = hi_q;
    pending_d    = pending_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (byte_done_s) begin
      data_d = shift_q;
      if (!pending_q) begin
        hi_d      = shift_q;
        pending_d = 1'b1;
      end else begin
        word_d       = {hi_q, shift_q};
        word_valid_d = 1'b1;
        pending_d    = 1'b0;
      end
    end else if (frame_err_s || idle_rise_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      sync_q       <= 2'b11;
      filt_sh_q    <= 3'b111;
      state_q      <= StIdle;
      phase_q      <= 4'd0;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'd0;
      idle_cnt_q   <= 12'd0;
      idle_q       <= 1'b0;
      pending_q    <= 1'b0;
      hi_q         <= 8'd0;
      data_q       <= 8'd0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      word_q       <= 16'd0;
      word_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      sync_q       <= {sync_q[0], RxD};
      filt_sh_q    <= filt_sh_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      idle_cnt_q   <= idle_cnt_d;
      idle_q       <= idle_d;
      pending_q    <= pending_d;
      hi_q         <= hi_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_ready = ready_q;
  assign rx_frame_err  = err_q;
  assign rx_word       = word_q;
  assign rx_word_valid = word_valid_q;
  assign rx_idle       = idle_q;

endmodule

// File: tb/tb_async_receiver_word.sv
// Bench for async_receiver_word: serial frames driven at bit level, a
// negedge monitor logs pulses, and directed vectors compare counts and
// held outputs against hand-computed values.
`timescale 1ns/1ps

module tb_async_receiver_word;

  localparam real BitNs  = 1.0e9 / 115200.0;
  localparam real TickNs = 20.0 * 65536.0 / 2416.0;

  logic        clk;
  logic        rst;
  logic        RxD;
  logic [7:0]  rx_data;
  logic        rx_data_ready;
  logic        rx_frame_err;
  logic [15:0] rx_word;
  logic        rx_word_valid;
  logic        rx_idle;

  async_receiver_word dut (
    .clk          (clk),
    .rst          (rst),
    .RxD          (RxD),
    .rx_data      (rx_data),
    .rx_data_ready(rx_data_ready),
    .rx_frame_err (rx_frame_err),
    .rx_word      (rx_word),
    .rx_word_valid(rx_word_valid),
    .rx_idle      (rx_idle)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int err_cnt = 0;
  int word_cnt = 0;
  int both_cnt = 0;
  int rst_pulse_cnt = 0;
  logic [7:0] data_log[$];

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_data_ready) begin
      ready_cnt <= ready_cnt + 1;
      data_log.push_back(rx_data);
    end
    if (rx_frame_err) err_cnt <= err_cnt + 1;
    if (rx_word_valid) word_cnt <= word_cnt + 1;
    if (rx_data_ready && rx_frame_err) both_cnt <= both_cnt + 1;
    if (rst && (rx_data_ready || rx_frame_err || rx_word_valid)) rst_pulse_cnt <= rst_pulse_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_stop, input real bit_ns);
    RxD = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      #(bit_ns);
    end
    RxD = ~bad_stop;
    #(bit_ns);
    RxD = 1'b1;
  endtask

  typedef struct {
    int          n;
    logic [7:0]  b0, b1, b2;
    logic [2:0]  bad;
    int          exp_ready;
    int          exp_err;
    int          exp_words;
    logic [15:0] exp_word;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs[3];

  int r0, e0, w0;
  logic [7:0] cur;

  initial begin
    vecs[0] = '{2, 8'h12, 8'h34, 8'h00, 3'b000, 2, 0, 1, 16'h1234, 8'h12, 8'h34};
    vecs[1] = '{3, 8'hA5, 8'h3C, 8'h7E, 3'b001, 2, 1, 1, 16'h3C7E, 8'h3C, 8'h7E};
    vecs[2] = '{2, 8'hFF, 8'h00, 8'h00, 3'b000, 2, 0, 1, 16'hFF00, 8'hFF, 8'h00};

    // Reset state and idle detection.
    rst = 1'b1;
    RxD = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_ready", 32'(rx_data_ready), 32'h0);
    check("reset_frame_err", 32'(rx_frame_err), 32'h0);
    check("reset_rx_word", 32'(rx_word), 32'h0);
    check("reset_word_valid", 32'(rx_word_valid), 32'h0);
    check("reset_idle", 32'(rx_idle), 32'h0);
    rst = 1'b0;
    #(11.0 * BitNs);
    check("idle_not_yet", 32'(rx_idle), 32'h0);
    #(2.0 * BitNs);
    check("idle_risen", 32'(rx_idle), 32'h1);
    check("idle_no_ready", 32'(ready_cnt), 32'h0);
    check("idle_no_err", 32'(err_cnt), 32'h0);

    // Table-driven frame sequences.
    for (int v = 0; v < 3; v++) begin
      r0 = ready_cnt; e0 = err_cnt; w0 = word_cnt;
      data_log.delete();
      for (int k = 0; k < vecs[v].n; k++) begin
        cur = (k == 0) ? vecs[v].b0 : (k == 1) ? vecs[v].b1 : vecs[v].b2;
        send_byte(cur, vecs[v].bad[k], BitNs);
        if (vecs[v].bad[k]) #(2.0 * BitNs);
      end
      #(3.0 * BitNs);
      check($sformatf("v%0d_ready", v), 32'(ready_cnt - r0), 32'(vecs[v].exp_ready));
      check($sformatf("v%0d_err", v), 32'(err_cnt - e0), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_words", v), 32'(word_cnt - w0), 32'(vecs[v].exp_words));
      check($sformatf("v%0d_word", v), 32'(rx_word), 32'(vecs[v].exp_word));
      check($sformatf("v%0d_first", v), 32'(data_log[0]), 32'(vecs[v].exp_first));
      check($sformatf("v%0d_last", v), 32'(rx_data), 32'(vecs[v].exp_last));
    end

    // Short glitch, then a lone byte followed by an idle gap.
    r0 = ready_cnt; e0 = err_cnt; w0 = word_cnt;
    RxD = 1'b0;
    #(3.0 * TickNs);
    RxD = 1'b1;
    #(2.0 * BitNs);
    check("glitch_ready", 32'(ready_cnt - r0), 32'h0);
    check("glitch_err", 32'(err_cnt - e0), 32'h0);
    data_log.delete();
    send_byte(8'h55, 1'b0, BitNs);
    #(20.0 * BitNs);
    check("gap_idle", 32'(rx_idle), 32'h1);
    check("gap_byte", 32'(rx_data), 32'h55);
    check("gap_no_word", 32'(word_cnt - w0), 32'h0);
    send_byte(8'h01, 1'b0, BitNs);
    send_byte(8'h02, 1'b0, BitNs);
    #(3.0 * BitNs);
    check("gap_ready", 32'(ready_cnt - r0), 32'h3);
    check("gap_words", 32'(word_cnt - w0), 32'h1);
    check("gap_word", 32'(rx_word), 32'h0102);

    // Reset in the middle of a frame, then frames 3% fast.
    r0 = ready_cnt; e0 = err_cnt; w0 = word_cnt;
    RxD = 1'b0;
    #(BitNs);
    RxD = 1'b1;
    #(4.5 * BitNs);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_word", 32'(rx_word), 32'h0);
    check("midrst_data", 32'(rx_data), 32'h0);
    rst = 1'b0;
    #(2.0 * BitNs);
    data_log.delete();
    send_byte(8'hC3, 1'b0, BitNs / 1.03);
    send_byte(8'h99, 1'b0, BitNs / 1.03);
    #(3.0 * BitNs);
    check("fast_ready", 32'(ready_cnt - r0), 32'h2);
    check("fast_err", 32'(err_cnt - e0), 32'h0);
    check("fast_words", 32'(word_cnt - w0), 32'h1);
    check("fast_word", 32'(rx_word), 32'hC399);
    check("fast_first", 32'(data_log[0]), 32'hC3);

    check("pulse_overlap", 32'(both_cnt), 32'h0);
    check("rst_pulses", 32'(rst_pulse_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
